bcd_clock_core: RTL and testbench
=================================

Name: bcd_clock_core

Overview:
Self-contained time-of-day keeper: 1 Hz prescaler, BCD seconds/minutes/hours counters, time-set controls, 12/24-hour display formatting. Drives the 24-bit packed HHMMSS word consumed by the seven-segment display driver. Replaces separately instantiated sec/min/hour counters plus the packing register. Internal time is always held in 24-hour BCD; 12-hour form exists only on the output.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second tick; legal range >= 2.
RESET_TIME, 24'h000000, BCD HHMMSS loaded at reset; must be a valid 24h time.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
run  in  1  1 = prescaler counts and time advances; 0 = prescaler and time hold
mode_12h  in  1  1 = 12-hour display format; 0 = 24-hour
load  in  1  single-cycle strobe: set time from load_time
load_time  in  24  BCD {H1,H0,M1,M0,S1,S0}, always 24-hour form
inc_min  in  1  single-cycle strobe: minutes +1 mod 60, no carry into hours
inc_hour  in  1  single-cycle strobe: hours +1 mod 24
freeze  in  1  1 = count/pm hold last value; internal time keeps running
count  out  24  displayed BCD {H1,H0,M1,M0,S1,S0}, registered
pm  out  1  1 when internal hour >= 12 (valid in both modes), registered
sec_tick  out  1  one-cycle pulse on each tick-driven seconds update
day_wrap  out  1  one-cycle pulse on tick-driven 23:59:59 -> 00:00:00
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst=1 at edge): time <= RESET_TIME; prescaler <= 0; count <= RESET_TIME formatted for current mode_12h; pm from RESET_TIME; sec_tick, day_wrap, load_err <= 0. rst overrides all inputs.
- Prescaler: 0..TICKS_PER_SEC-1, increments while run=1, holds while run=0. Tick = prescaler at TICKS_PER_SEC-1 with run=1; prescaler wraps to 0 that edge.
- Per-edge priority (after rst): load > inc_min/inc_hour > tick.
- Load: valid iff every digit <= 9, H <= 23, M <= 59, S <= 59. Valid: time <= load_time, prescaler <= 0. Invalid: time and prescaler unchanged, load_err = 1 next cycle. Strobes and tick in same cycle as load are dropped.
- inc_min/inc_hour (no load): seconds <= 00, prescaler <= 0; minutes 59 -> 00 with hours untouched; hours 23 -> 00. Both high same cycle: both applied. Coincident tick dropped. No sec_tick/day_wrap.
- Tick (nothing higher): S0 9->0 carries S1; S1:S0 59->00 carries minutes; 59->00 carries hours; 23:59:59 -> 00:00:00 asserts day_wrap. sec_tick=1 on every tick-driven update. Both pulses registered, same edge as time update.
- Output: count/pm register internal time one cycle later (latency 1 from internal update to count). 24h mode: hours as is. 12h mode: 00 -> 12, 01-12 unchanged, 13-23 -> minus 12 (BCD-correct, e.g. 20 -> 08). mode_12h change visible on count next edge.
- freeze=1: count and pm hold; on release, next edge shows current internal time. freeze does not block load/inc/tick, sec_tick, day_wrap, load_err.
- Strobes held high >1 cycle act every cycle (edge detection is upstream's job).

Test Plan:
- TICKS_PER_SEC=4, RESET_TIME=0, rst then run=1 for 12 cycles -> sec_tick every 4th cycle, count = 24'h000003 one cycle after third pulse; run=0 for 10 cycles -> count unchanged.
- load 24'h235958, run=1, 8 cycles -> 23:59:59 then 00:00:00 with day_wrap single pulse coincident with sec_tick; count 24'h000000 one cycle later.
- load 24'h246000 -> load_err pulse, time unchanged; load 24'h125960 -> load_err; load 24'h095900 -> accepted, no load_err.
- load 24'h005930, mode_12h=1 -> count 24'h125930, pm=0; load 24'h134500 -> count 24'h014500, pm=1; mode_12h=0 -> 24'h134500 next edge.
- load 24'h235930, inc_min and inc_hour same cycle coincident with tick -> time 00:00:00, no sec_tick, no day_wrap; inc_min alone at 10:59:xx -> 10:00:00.
- freeze=1 at count 24'h000010, run 3 s -> count held, sec_tick still pulsing; freeze=0 -> count 24'h000013 next edge; rst asserted mid-run -> all outputs at reset values next edge.

Source files
------------

// File: rtl/bcd_clock_core.sv
// bcd_clock_core: time-of-day keeper with 1 Hz prescaler, 24-hour BCD time
// registers, load/increment controls and a registered 12/24-hour HHMMSS output.
module bcd_clock_core #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter logic [23:0] RESET_TIME    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] load_time,
    input  logic        inc_min,
    input  logic        inc_hour,
    input  logic        freeze,
    output logic [23:0] count,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_wrap,
    output logic        load_err
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_hh;
    logic [7:0]    r_mm;
    logic [7:0]    r_ss;
    logic [23:0]   r_count;
    logic          r_pm;
    logic          r_sec_tick;
    logic          r_day_wrap;
    logic          r_load_err;

    logic          w_tick;
    logic          w_load_ok;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24-hour BCD hour to displayed hour; 12-hour form maps 00->12, 13..23->01..11.
    function automatic logic [7:0] fmt_hour(input logic [7:0] h, input logic m12);
        logic [3:0] lo;
        lo = 4'h0;
        if (!m12)
            return h;
        if (h == 8'h00)
            return 8'h12;
        if (h <= 8'h12)
            return h;
        if (h[7:4] == 4'h1)
            return h - 8'h12;
        // 20..23: subtracting 12 equals adding 8 to the units digit with a decimal carry
        lo = h[3:0] + 4'd8;
        if (lo >= 4'd10)
            return {4'h1, lo - 4'd10};
        return {4'h0, lo};
    endfunction

    // A load is accepted only for a well-formed 24-hour BCD time.
    function automatic logic time_ok(input logic [23:0] t);
        logic digits_ok;
        digits_ok = (t[23:20] <= 4'h9) && (t[19:16] <= 4'h9) &&
                    (t[15:12] <= 4'h9) && (t[11:8]  <= 4'h9) &&
                    (t[7:4]   <= 4'h9) && (t[3:0]   <= 4'h9);
        return digits_ok && (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
    endfunction

    assign w_tick    = run && (r_presc == PMAX);
    assign w_load_ok = time_ok(load_time);

    // Time registers, prescaler and event pulses; load beats increments beats tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hh       <= RESET_TIME[23:16];
            r_mm       <= RESET_TIME[15:8];
            r_ss       <= RESET_TIME[7:0];
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_hh    <= load_time[23:16];
                    r_mm    <= load_time[15:8];
                    r_ss    <= load_time[7:0];
                    r_presc <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (inc_min || inc_hour) begin
                r_ss    <= 8'h00;
                r_presc <= '0;
                if (inc_min)
                    r_mm <= bcd_inc(r_mm, 8'h59);
                if (inc_hour)
                    r_hh <= bcd_inc(r_hh, 8'h23);
            end else if (w_tick) begin
                r_presc    <= '0;
                r_sec_tick <= 1'b1;
                r_ss       <= bcd_inc(r_ss, 8'h59);
                if (r_ss == 8'h59) begin
                    r_mm <= bcd_inc(r_mm, 8'h59);
                    if (r_mm == 8'h59) begin
                        r_hh <= bcd_inc(r_hh, 8'h23);
                        if (r_hh == 8'h23)
                            r_day_wrap <= 1'b1;
                    end
                end
            end else if (run) begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Display register: formatted copy of the internal time, held while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {fmt_hour(RESET_TIME[23:16], mode_12h), RESET_TIME[15:0]};
            r_pm    <= (RESET_TIME[23:16] >= 8'h12);
        end else if (!freeze) begin
            r_count <= {fmt_hour(r_hh, mode_12h), r_mm, r_ss};
            r_pm    <= (r_hh >= 8'h12);
        end
    end

    assign count    = r_count;
    assign pm       = r_pm;
    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_clock_core.sv
// Testbench for bcd_clock_core with TICKS_PER_SEC=4: per-scenario stimulus
// tables, expected outputs queued at drive time and compared after the edge.
module tb_bcd_clock_core;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mode_12h;
    logic        load;
    logic [23:0] load_time;
    logic        inc_min;
    logic        inc_hour;
    logic        freeze;
    logic [23:0] count;
    logic        pm;
    logic        sec_tick;
    logic        day_wrap;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    // control bit positions: {rst, run, mode_12h, load, inc_min, inc_hour, freeze}
    localparam logic [6:0] RST = 7'h40;
    localparam logic [6:0] RUN = 7'h20;
    localparam logic [6:0] M12 = 7'h10;
    localparam logic [6:0] LD  = 7'h08;
    localparam logic [6:0] IM  = 7'h04;
    localparam logic [6:0] IH  = 7'h02;
    localparam logic [6:0] FRZ = 7'h01;
    localparam logic [6:0] NONE = 7'h00;

    typedef struct packed {
        logic [23:0] c;
        logic        p;
        logic        st;
        logic        dw;
        logic        le;
    } obs_t;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [23:0] lt;
        logic        chk;
        obs_t        e;
    } stim_t;

    obs_t exp_q[$];

    bcd_clock_core #(
        .TICKS_PER_SEC(4),
        .RESET_TIME   (24'h000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode_12h (mode_12h),
        .load     (load),
        .load_time(load_time),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .freeze   (freeze),
        .count    (count),
        .pm       (pm),
        .sec_tick (sec_tick),
        .day_wrap (day_wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // flags = {pm, sec_tick, day_wrap, load_err}
    function automatic stim_t S(input logic [6:0] ctl, input logic [23:0] lt,
                                input logic chk, input logic [23:0] ec, input logic [3:0] fl);
        stim_t s;
        s.ctl  = ctl;
        s.lt   = lt;
        s.chk  = chk;
        s.e.c  = ec;
        s.e.p  = fl[3];
        s.e.st = fl[2];
        s.e.dw = fl[1];
        s.e.le = fl[0];
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.c  = count;
        o.p  = pm;
        o.st = sec_tick;
        o.dw = day_wrap;
        o.le = load_err;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        {rst, run, mode_12h, load, inc_min, inc_hour, freeze} = s.ctl;
        load_time = s.lt;
    endtask

    task automatic test_reset();
        stim_t rows[$];
        obs_t  got, ex;
        rows.push_back(S(RST,       24'h0, 1'b1, 24'h000000, 4'b0000));
        rows.push_back(S(RST | M12, 24'h0, 1'b1, 24'h120000, 4'b0000));
        rows.push_back(S(RST,       24'h0, 1'b1, 24'h000000, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL reset[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_tick();
        stim_t rows[$];
        obs_t  got, ex;
        for (int i = 0; i < 12; i++)
            rows.push_back(S(RUN, 24'h0, 1'b1, 24'(i / 4), {1'b0, (i % 4) == 3, 2'b00}));
        for (int i = 0; i < 11; i++)
            rows.push_back(S(NONE, 24'h0, 1'b1, 24'h000003, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL tick[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_day_wrap();
        stim_t rows[$];
        obs_t  got, ex;
        rows.push_back(S(RUN | LD, 24'h235958, 1'b1, 24'h000003, 4'b0000));
        for (int j = 1; j <= 9; j++) begin
            if (j <= 4)
                rows.push_back(S(RUN, 24'h0, 1'b1, 24'h235958, {1'b1, j == 4, 2'b00}));
            else if (j <= 8)
                rows.push_back(S(RUN, 24'h0, 1'b1, 24'h235959, {1'b1, j == 8, j == 8, 1'b0}));
            else
                rows.push_back(S(RUN, 24'h0, 1'b1, 24'h000000, 4'b0000));
        end
        rows.push_back(S(NONE, 24'h0, 1'b1, 24'h000000, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL day_wrap[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_load_err();
        stim_t rows[$];
        obs_t  got, ex;
        logic [23:0] bad[4];
        bad[0] = 24'h246000;
        bad[1] = 24'h125960;
        bad[2] = 24'h0A0000;
        bad[3] = 24'h000060;
        for (int k = 0; k < 4; k++) begin
            rows.push_back(S(LD,   bad[k], 1'b1, 24'h000000, 4'b0001));
            rows.push_back(S(NONE, 24'h0,  1'b1, 24'h000000, 4'b0000));
        end
        rows.push_back(S(LD,   24'h095900, 1'b1, 24'h000000, 4'b0000));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h095900, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL load_err[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_12h();
        stim_t rows[$];
        obs_t  got, ex;
        logic [23:0] t24[5];
        logic [23:0] t12[5];
        logic        tpm[5];
        t24[0] = 24'h005930; t12[0] = 24'h125930; tpm[0] = 1'b0;
        t24[1] = 24'h120000; t12[1] = 24'h120000; tpm[1] = 1'b1;
        t24[2] = 24'h205500; t12[2] = 24'h085500; tpm[2] = 1'b1;
        t24[3] = 24'h221000; t12[3] = 24'h101000; tpm[3] = 1'b1;
        t24[4] = 24'h134500; t12[4] = 24'h014500; tpm[4] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rows.push_back(S(M12 | LD, t24[k], 1'b0, 24'h0, 4'b0000));
            rows.push_back(S(M12, 24'h0, 1'b1, t12[k], {tpm[k], 3'b000}));
        end
        rows.push_back(S(NONE, 24'h0, 1'b1, 24'h134500, 4'b1000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL mode12[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_inc();
        stim_t rows[$];
        obs_t  got, ex;
        rows.push_back(S(RUN | LD, 24'h235930, 1'b1, 24'h134500, 4'b1000));
        for (int k = 0; k < 3; k++)
            rows.push_back(S(RUN, 24'h0, 1'b1, 24'h235930, 4'b1000));
        rows.push_back(S(RUN | IM | IH, 24'h0, 1'b1, 24'h235930, 4'b1000));
        for (int k = 1; k <= 4; k++)
            rows.push_back(S(RUN, 24'h0, 1'b1, 24'h000000, {1'b0, k == 4, 2'b00}));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h000001, 4'b0000));
        rows.push_back(S(LD,   24'h105842, 1'b1, 24'h000001, 4'b0000));
        rows.push_back(S(IM,   24'h0,      1'b1, 24'h105842, 4'b0000));
        rows.push_back(S(IM,   24'h0,      1'b1, 24'h105900, 4'b0000));
        rows.push_back(S(IM,   24'h0,      1'b1, 24'h100000, 4'b0000));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h100100, 4'b0000));
        rows.push_back(S(LD,   24'h095930, 1'b1, 24'h100100, 4'b0000));
        rows.push_back(S(IH,   24'h0,      1'b1, 24'h095930, 4'b0000));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h105900, 4'b0000));
        rows.push_back(S(LD,   24'h231000, 1'b1, 24'h105900, 4'b0000));
        rows.push_back(S(IH,   24'h0,      1'b1, 24'h231000, 4'b1000));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h001000, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL inc[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_freeze();
        stim_t rows[$];
        obs_t  got, ex;
        rows.push_back(S(LD,   24'h000010, 1'b1, 24'h001000, 4'b0000));
        rows.push_back(S(NONE, 24'h0,      1'b1, 24'h000010, 4'b0000));
        for (int i = 0; i < 12; i++)
            rows.push_back(S(RUN | FRZ, 24'h0, 1'b1, 24'h000010, {1'b0, (i % 4) == 3, 2'b00}));
        rows.push_back(S(FRZ | LD, 24'h999999, 1'b1, 24'h000010, 4'b0001));
        rows.push_back(S(NONE, 24'h0, 1'b1, 24'h000013, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL freeze[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t rows[$];
        obs_t  got, ex;
        for (int k = 0; k < 6; k++)
            rows.push_back(S(RUN, 24'h0, 1'b0, 24'h0, 4'b0000));
        rows.push_back(S(RST | M12 | RUN | LD | IM, 24'h999999, 1'b1, 24'h120000, 4'b0000));
        for (int k = 1; k <= 4; k++)
            rows.push_back(S(RUN, 24'h0, 1'b1, 24'h000000, {1'b0, k == 4, 2'b00}));
        rows.push_back(S(NONE, 24'h0, 1'b1, 24'h000001, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            if (rows[i].chk) exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            if (rows[i].chk) begin
                ex = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL reset_mid[%0d]: got c=%h p=%b st=%b dw=%b le=%b, expected c=%h p=%b st=%b dw=%b le=%b",
                             i, got.c, got.p, got.st, got.dw, got.le, ex.c, ex.p, ex.st, ex.dw, ex.le);
                end
            end
        end
    endtask

    initial begin
        {rst, run, mode_12h, load, inc_min, inc_hour, freeze} = 7'h40;
        load_time = 24'h0;
        @(negedge clk);
        test_reset();
        test_tick();
        test_day_wrap();
        test_load_err();
        test_12h();
        test_inc();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
